// File: rtl/delta_frame_ctrl_pkg.sv
// Shared types and constants for the delta-cepstrum frame controller.
// Edge handling is selected by DELTA_EDGE_REPLICATE_EN (see delta_tap_addr_gen).
package delta_frame_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ISSUE,
    S_NEXT,
    S_DONE
  } state_t;

  localparam int unsigned T_START_NOCLAMP = 4;
  localparam int unsigned TAP_NUM         = 4;

  typedef logic signed [2:0] weight_t;

  localparam weight_t W_M2 = -3'sd2;
  localparam weight_t W_M1 = -3'sd1;
  localparam weight_t W_P1 = 3'sd1;
  localparam weight_t W_P2 = 3'sd2;

endpackage

// File: rtl/delta_tap_addr_gen.sv
// Combinational tap address/weight generator for one delta tap of centre frame t.
// With DELTA_EDGE_REPLICATE_EN defined, addresses are clamped to [0, frame_total-1].
module delta_tap_addr_gen
  import delta_frame_ctrl_pkg::*;
#(
  parameter int unsigned COUNTER_VALUE_WIDTH = 7
) (
  input  logic [COUNTER_VALUE_WIDTH-1:0] t,
  input  logic [1:0]                     tap,
`ifdef DELTA_EDGE_REPLICATE_EN
  input  logic [COUNTER_VALUE_WIDTH-1:0] frame_total,
`endif
  output logic [COUNTER_VALUE_WIDTH-1:0] frame,
  output weight_t                        weight
);

  localparam int unsigned CW = COUNTER_VALUE_WIDTH;

`ifdef DELTA_EDGE_REPLICATE_EN
  logic [CW:0] t_ext;
  logic [CW:0] addr;
  logic [CW:0] lim;

  assign t_ext = {1'b0, t};
  assign lim   = {1'b0, frame_total} - (CW+1)'(1);

  always_comb begin
    weight = W_M2;
    addr   = t_ext - (CW+1)'(2);
    case (tap)
      2'd0: begin weight = W_M2; addr = t_ext - (CW+1)'(2); end
      2'd1: begin weight = W_M1; addr = t_ext - (CW+1)'(1); end
      2'd2: begin weight = W_P1; addr = t_ext + (CW+1)'(1); end
      default: begin weight = W_P2; addr = t_ext + (CW+1)'(2); end
    endcase
    // t-1/t-2 below zero wraps into the spare top bit
    if (!tap[1] && addr[CW])
      addr = '0;
    else if (tap[1] && (addr > lim))
      addr = lim;
    frame = addr[CW-1:0];
  end
`else
  always_comb begin
    weight = W_M2;
    frame  = t - CW'(2);
    case (tap)
      2'd0: begin weight = W_M2; frame = t - CW'(2); end
      2'd1: begin weight = W_M1; frame = t - CW'(1); end
      2'd2: begin weight = W_P1; frame = t + CW'(1); end
      default: begin weight = W_P2; frame = t + CW'(2); end
    endcase
  end
`endif

endmodule

// File: rtl/delta_frame_ctrl.sv
// Sequences the 4-tap delta regression over all coefficients of each centre frame.
// Macro DELTA_EDGE_REPLICATE_EN enables edge-replicated (clamped) frames 0..frame_total-1.
module delta_frame_ctrl
  import delta_frame_ctrl_pkg::*;
#(
  parameter int unsigned COUNTER_VALUE_WIDTH = 7,
  parameter int unsigned COEF_NUM            = 13,
  parameter int unsigned COEF_WIDTH          = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [COUNTER_VALUE_WIDTH-1:0] frame_total,
  input  logic [COUNTER_VALUE_WIDTH-1:0] frame_avail,
  output logic                           req_valid,
  input  logic                           req_ready,
  output logic [COUNTER_VALUE_WIDTH-1:0] req_frame,
  output logic [COEF_WIDTH-1:0]          req_coef,
  output logic signed [2:0]              req_weight,
  output logic                           req_first,
  output logic                           req_last,
  output logic [COUNTER_VALUE_WIDTH-1:0] out_frame,
  output logic                           busy,
  output logic                           done,
  output logic                           err
);

  localparam int unsigned CW = COUNTER_VALUE_WIDTH;

  state_t                state;
  logic [CW-1:0]         t;
  logic [CW-1:0]         tot;
  logic [COEF_WIDTH-1:0] coef;
  logic [1:0]            tap;

  logic [CW-1:0]         t_start;
  logic [CW-1:0]         t_end;
  logic                  too_short;
  logic [CW-1:0]         gen_t;
  logic [1:0]            gen_tap;
  logic [CW-1:0]         gen_frame;
  weight_t               gen_weight;
  logic [CW:0]           need_pos;
  logic                  avail_ok;
  logic                  hs;
  logic                  last_tap;
  logic                  last_coef;
  logic                  enter_issue;

`ifdef DELTA_EDGE_REPLICATE_EN
  assign t_start   = '0;
  assign t_end     = tot - CW'(1);
  assign too_short = (frame_total == '0);
`else
  assign t_start   = CW'(T_START_NOCLAMP);
  assign t_end     = tot - CW'(5);
  assign too_short = (frame_total < CW'(9));
`endif

  // NEXT evaluates readiness of t+1 so a frame boundary costs a single idle cycle
  assign gen_t    = (state == S_NEXT) ? (t + CW'(1)) : t;
  assign gen_tap  = (state == S_ISSUE) ? (tap + 2'd1) : 2'd0;
  assign need_pos = {1'b0, gen_t} + (CW+1)'(3);
  assign avail_ok = {1'b0, frame_avail} >= ((need_pos < {1'b0, tot}) ? need_pos : {1'b0, tot});

  assign hs        = req_valid && req_ready;
  assign last_tap  = (tap == 2'(TAP_NUM - 1));
  assign last_coef = (coef == COEF_WIDTH'(COEF_NUM - 1));
  assign enter_issue = avail_ok && ((state == S_WAIT) || ((state == S_NEXT) && (t != t_end)));
  assign out_frame = t;

  delta_tap_addr_gen #(
    .COUNTER_VALUE_WIDTH(CW)
  ) u_addr (
    .t          (gen_t),
    .tap        (gen_tap),
`ifdef DELTA_EDGE_REPLICATE_EN
    .frame_total(tot),
`endif
    .frame      (gen_frame),
    .weight     (gen_weight)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      t          <= CW'(T_START_NOCLAMP);
      tot        <= '0;
      coef       <= '0;
      tap        <= '0;
      req_valid  <= 1'b0;
      req_frame  <= '0;
      req_coef   <= '0;
      req_weight <= '0;
      req_first  <= 1'b0;
      req_last   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            err  <= too_short;
            tot  <= frame_total;
            t    <= t_start;
            coef <= '0;
            tap  <= '0;
            if (too_short) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_WAIT;
              busy  <= 1'b1;
            end
          end
        end
        S_WAIT: ;
        S_ISSUE: begin
          if (hs) begin
            if (last_tap && last_coef) begin
              state     <= S_NEXT;
              req_valid <= 1'b0;
              req_first <= 1'b0;
              req_last  <= 1'b0;
            end else begin
              tap        <= gen_tap;
              req_frame  <= gen_frame;
              req_weight <= gen_weight;
              req_first  <= (gen_tap == 2'd0);
              req_last   <= (gen_tap == 2'(TAP_NUM - 1));
              if (last_tap) begin
                coef     <= coef + COEF_WIDTH'(1);
                req_coef <= coef + COEF_WIDTH'(1);
              end
            end
          end
        end
        S_NEXT: begin
          if (t == t_end) begin
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            t     <= gen_t;
            state <= S_WAIT;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      if (enter_issue) begin
        state      <= S_ISSUE;
        req_valid  <= 1'b1;
        req_first  <= 1'b1;
        req_last   <= 1'b0;
        req_frame  <= gen_frame;
        req_weight <= gen_weight;
        req_coef   <= '0;
        coef       <= '0;
        tap        <= '0;
      end
    end
  end

endmodule

// File: tb/tb_delta_frame_ctrl.sv
// Directed bench for delta_frame_ctrl with a frame/tap list model and a per-handshake checker.
module tb_delta_frame_ctrl;

  localparam int COEF_N = 13;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [6:0]        frame_total = '0;
  logic [6:0]        frame_avail = '0;
  logic              req_valid;
  logic              req_ready = 1'b0;
  logic [6:0]        req_frame;
  logic [3:0]        req_coef;
  logic signed [2:0] req_weight;
  logic              req_first;
  logic              req_last;
  logic [6:0]        out_frame;
  logic              busy;
  logic              done;
  logic              err;

  delta_frame_ctrl #(
    .COUNTER_VALUE_WIDTH(7),
    .COEF_NUM(COEF_N),
    .COEF_WIDTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .frame_total(frame_total), .frame_avail(frame_avail),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_frame(req_frame), .req_coef(req_coef), .req_weight(req_weight),
    .req_first(req_first), .req_last(req_last),
    .out_frame(out_frame), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int frame;
    int coef;
    int weight;
    int t;
    bit first;
    bit last;
  } tap_s;

  tap_s exp_q[$];
  int   log_q[$];
  int   nvec = 0;
  int   nerr = 0;
  int   hs_cnt = 0;
  int   stall_cnt = 0;

  bit                prev_stall = 1'b0;
  logic [6:0]        p_frame;
  logic [3:0]        p_coef;
  logic signed [2:0] p_weight;
  logic              p_first;
  logic              p_last;

  task automatic chk(input string name, input int got, input int expv);
    nvec++;
    if (got !== expv) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, expv, $time);
    end
  endtask

  // Expected tap list: every centre frame, every coefficient, offsets -2,-1,+1,+2 (weight = offset)
  task automatic model_load(input int ft);
    int offs[4];
    int ts, te, a;
    tap_s e;
    offs = '{-2, -1, 1, 2};
`ifdef DELTA_EDGE_REPLICATE_EN
    ts = 0; te = ft - 1;
`else
    ts = 4; te = ft - 5;
`endif
    exp_q.delete();
    for (int tt = ts; tt <= te; tt++)
      for (int c = 0; c < COEF_N; c++)
        for (int k = 0; k < 4; k++) begin
          a = tt + offs[k];
`ifdef DELTA_EDGE_REPLICATE_EN
          if (a < 0) a = 0;
          if (a > ft - 1) a = ft - 1;
`endif
          e.frame = a; e.coef = c; e.weight = offs[k]; e.t = tt;
          e.first = (k == 0); e.last = (k == 3);
          exp_q.push_back(e);
        end
  endtask

  always @(negedge clk) begin
    tap_s e;
    if (rst_n && prev_stall) begin
      chk("stall_valid", int'(req_valid), 1);
      chk("stall_frame", int'(req_frame), int'(p_frame));
      chk("stall_coef", int'(req_coef), int'(p_coef));
      chk("stall_weight", int'(req_weight), int'(p_weight));
      chk("stall_first", int'(req_first), int'(p_first));
      chk("stall_last", int'(req_last), int'(p_last));
    end
    if (rst_n && req_valid && req_ready) begin
      hs_cnt++;
      log_q.push_back(int'(req_frame));
      if (exp_q.size() == 0) begin
        chk("unexpected_tap", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("tap_frame", int'(req_frame), e.frame);
        chk("tap_coef", int'(req_coef), e.coef);
        chk("tap_weight", int'(req_weight), e.weight);
        chk("tap_first", int'(req_first), int'(e.first));
        chk("tap_last", int'(req_last), int'(e.last));
        chk("tap_centre", int'(out_frame), e.t);
      end
    end
    prev_stall = rst_n && req_valid && !req_ready;
    if (prev_stall) stall_cnt++;
    p_frame = req_frame; p_coef = req_coef; p_weight = req_weight;
    p_first = req_first; p_last = req_last;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_reset(input string p);
    chk({p, "_valid"}, int'(req_valid), 0);
    chk({p, "_busy"}, int'(busy), 0);
    chk({p, "_done"}, int'(done), 0);
    chk({p, "_err"}, int'(err), 0);
    chk({p, "_frame"}, int'(req_frame), 0);
    chk({p, "_coef"}, int'(req_coef), 0);
    chk({p, "_weight"}, int'(req_weight), 0);
    chk({p, "_first"}, int'(req_first), 0);
    chk({p, "_last"}, int'(req_last), 0);
    chk({p, "_t"}, int'(out_frame), 4);
  endtask

  task automatic run_to_done(input int bound, input bit bp, output int cycles);
    cycles = 0;
    while (cycles < bound) begin
      if (bp) req_ready = ((cycles % 4) == 0) || ((cycles % 4) == 3);
      tick();
      cycles++;
      if (done) break;
    end
    chk("done_seen", int'(done), 1);
    req_ready = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cyc, bad;
    int first4[4];

    tick(); tick();
    check_reset("reset");
    rst_n = 1'b1;
    tick();

    // Nominal pass
    model_load(12);
    hs_cnt = 0; log_q.delete();
    frame_total = 12; frame_avail = 12; req_ready = 1'b1;
    pulse_start();
    chk("nom_busy", int'(busy), 1);
    n = 0;
    while (!req_valid && n < 20) begin tick(); n++; end
    chk("nom_first_valid", int'(req_valid), 1);
    chk("nom_wait_cycles", n, 1);
`ifndef DELTA_EDGE_REPLICATE_EN
    chk("nom_first_frame", int'(req_frame), 2);
    chk("nom_first_weight", int'(req_weight), -2);
    chk("nom_first_flag", int'(req_first), 1);
    chk("nom_first_t", int'(out_frame), 4);
`endif
    run_to_done(1000, 1'b0, cyc);
`ifndef DELTA_EDGE_REPLICATE_EN
    chk("nom_latency", cyc, 212);
    chk("nom_handshakes", hs_cnt, 208);
`else
    chk("nom_latency", cyc, 12 * 52 + 12);
    chk("nom_handshakes", hs_cnt, 12 * 52);
`endif
    chk("nom_busy_at_done", int'(busy), 0);
    chk("nom_err", int'(err), 0);
    chk("nom_model_drained", exp_q.size(), 0);
    tick();
    chk("nom_done_pulse", int'(done), 0);

    // Too short
    exp_q.delete();
`ifdef DELTA_EDGE_REPLICATE_EN
    frame_total = 0;
`else
    frame_total = 8;
`endif
    pulse_start();
    chk("short_done", int'(done), 1);
    chk("short_err", int'(err), 1);
    chk("short_busy", int'(busy), 0);
    chk("short_valid", int'(req_valid), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("short_done_pulse", int'(done), 0);
    chk("short_err_sticky", int'(err), 1);
    tick();
    chk("start_in_done_ignored", int'(done), 0);
    chk("short_no_valid", int'(req_valid), 0);

    // Backpressure
    model_load(9);
    hs_cnt = 0; stall_cnt = 0; log_q.delete();
    frame_total = 9; frame_avail = 9;
    pulse_start();
    chk("err_cleared_by_start", int'(err), 0);
    run_to_done(3000, 1'b1, cyc);
`ifndef DELTA_EDGE_REPLICATE_EN
    chk("bp_handshakes", hs_cnt, 52);
    first4 = '{2, 3, 5, 6};
`else
    chk("bp_handshakes", hs_cnt, 9 * 52);
    first4 = '{0, 0, 1, 2};
`endif
    chk("bp_model_drained", exp_q.size(), 0);
    chk("bp_stalls_seen", int'(stall_cnt > 0), 1);
    if (log_q.size() >= 4)
      for (int i = 0; i < 4; i++) chk("bp_first_taps", log_q[i], first4[i]);
    else
      chk("bp_log_size", log_q.size(), 4);
    tick();

`ifndef DELTA_EDGE_REPLICATE_EN
    // Producer stall
    model_load(20);
    hs_cnt = 0;
    frame_total = 20; frame_avail = 6;
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("stall_hold_valid", int'(req_valid), 0);
    end
    chk("stall_hold_t", int'(out_frame), 4);
    chk("stall_hold_busy", int'(busy), 1);
    frame_avail = 7;
    tick();
    chk("stall_release", int'(req_valid), 1);
    chk("stall_release_frame", int'(req_frame), 2);
    n = 0;
    while (out_frame != 5 && n < 200) begin tick(); n++; end
    chk("stall_reach_t5", int'(out_frame), 5);
    for (int i = 0; i < 5; i++) tick();
    chk("stall_wait_t5", int'(req_valid), 0);
    frame_avail = 20;
    run_to_done(2000, 1'b0, cyc);
    chk("stall_handshakes", hs_cnt, 624);
    chk("stall_model_drained", exp_q.size(), 0);
    tick();
`endif

    // Mid-pass reset
    model_load(12);
    frame_total = 12; frame_avail = 12;
    pulse_start();
    n = 0;
    while (!(out_frame == 5 && req_valid) && n < 300) begin tick(); n++; end
    chk("mid_reach_t5", int'(out_frame == 5 && req_valid), 1);
    for (int i = 0; i < 10; i++) tick();
    rst_n = 1'b0;
    tick();
    check_reset("midreset");
    rst_n = 1'b1;
    exp_q.delete();
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (done || req_valid || busy) bad = 1;
    end
    chk("mid_no_activity", bad, 0);

`ifdef DELTA_EDGE_REPLICATE_EN
    // Edge replication, frame_total=3
    model_load(3);
    hs_cnt = 0; log_q.delete();
    frame_total = 3; frame_avail = 3;
    pulse_start();
    run_to_done(1000, 1'b0, cyc);
    chk("rep_latency", cyc, 3 * 52 + 3);
    chk("rep_handshakes", hs_cnt, 156);
    if (log_q.size() >= 108) begin
      first4 = '{0, 0, 1, 2};
      for (int i = 0; i < 4; i++) chk("rep_t0_taps", log_q[i], first4[i]);
      first4 = '{0, 1, 2, 2};
      for (int i = 0; i < 4; i++) chk("rep_t2_taps", log_q[104 + i], first4[i]);
    end else begin
      chk("rep_log_size", log_q.size(), 156);
    end
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
